// File: rtl/mmio_pkg.sv
// Purpose: shared region encoding, address bases and offsets for the MMIO controller.
// Latency: n/a (types, constants and a combinational decode helper only).
// Backpressure: n/a.
package mmio_pkg;

   // Region select driven to data_mem / vga char memory; encoding is part of the slave interface.
   typedef enum logic [2:0] {
      MT_NONE  = 3'd0,
      MT_DATA  = 3'd1,
      MT_VGA   = 3'd2,
      MT_KBD   = 3'd3,
      MT_LED   = 3'd4,
      MT_SW    = 3'd5,
      MT_SEG   = 3'd6,
      MT_TIMER = 3'd7
   } mem_type_t;

   // Region bases, compared against addr[31:20].
   localparam logic [11:0] RGN_DATA  = 12'h001;
   localparam logic [11:0] RGN_VGA   = 12'h002;
   localparam logic [11:0] RGN_KBD   = 12'h003;
   localparam logic [11:0] RGN_LED   = 12'h004;
   localparam logic [11:0] RGN_SW    = 12'h005;
   localparam logic [11:0] RGN_SEG   = 12'h006;
   localparam logic [11:0] RGN_TIMER = 12'h007;

   // Register offsets within a region, compared against addr[3:0].
   localparam logic [3:0] OFS_DATA = 4'h0;
   localparam logic [3:0] OFS_STAT = 4'h4;

   function automatic mem_type_t decode_region(input logic [11:0] rgn);
      mem_type_t mt;
      case (rgn)
         RGN_DATA:  mt = MT_DATA;
         RGN_VGA:   mt = MT_VGA;
         RGN_KBD:   mt = MT_KBD;
         RGN_LED:   mt = MT_LED;
         RGN_SW:    mt = MT_SW;
         RGN_SEG:   mt = MT_SEG;
         RGN_TIMER: mt = MT_TIMER;
         default:   mt = MT_NONE;
      endcase
      return mt;
   endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Purpose: circular scancode buffer with a sticky overflow flag.
// Latency: push/pop take effect at the clock edge; dout shows the head combinationally.
// Backpressure: none; a push into a full buffer (without a same-cycle pop) is dropped and flagged.
module kbd_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full,
   output logic       overflow,
   input  logic       clr_ovf
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          do_pop;
   logic          do_push;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign dout    = mem[rd_ptr];
   // A pop frees a slot in the same cycle, so a full buffer still accepts a simultaneous push.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of 2.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + (AW+1)'(1);
         else if (do_pop && !do_push) count <= count - (AW+1)'(1);
      end
   end

   // Sticky overflow; a dropped code in the same cycle as a clear keeps the flag set so the loss is visible.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)                        overflow <= 1'b0;
      else if (push && full && !do_pop)  overflow <= 1'b1;
      else if (clr_ovf)                  overflow <= 1'b0;
   end

   // Storage array; contents need no reset because empty reads never expose them.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_ctrl.sv
// Purpose: data-side address decode, LED/7-seg/timer registers, keyboard FIFO and read-data mux (timer logic built only with MMIO_TIMER_EN).
// Latency: mem_type combinational; stores at the clock edge; rdata valid one cycle after a re=1 request.
// Backpressure: none; every access completes in fixed time, keyboard codes beyond FIFO capacity are dropped and flagged.
module mmio_ctrl
   import mmio_pkg::*;
#(
   parameter int KBD_FIFO_DEPTH = 8,
   parameter int TIMER_DIV      = 50000
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic        re,
   output logic [2:0]  mem_type,
   input  logic [31:0] dmem_rdata,
   input  logic [31:0] vga_rdata,
   output logic [31:0] rdata,
   input  logic [15:0] sw,
   output logic [15:0] led,
   output logic [7:0]  seg_en,
   output logic [31:0] seg_data,
   input  logic        kbd_valid,
   input  logic [7:0]  kbd_code
);

   mem_type_t   rgn;
   logic [3:0]  ofs;
   logic        wr_led;
   logic        wr_seg;
   logic        wr_segen;
   logic        wr_ovf_clr;
   logic        kbd_pop;
   logic [7:0]  kbd_head;
   logic        kbd_empty;
   logic        kbd_full;
   logic        kbd_ovf;
   mem_type_t   sel_rgn;
   logic [3:0]  sel_ofs;
   logic [7:0]  kbd_q;
   logic [31:0] ms_cnt;
   logic        unused_ok;

   assign rgn      = decode_region(addr[31:20]);
   assign ofs      = addr[3:0];
   assign mem_type = rgn;

   assign wr_led     = we && (rgn == MT_LED) && (ofs == OFS_DATA);
   assign wr_seg     = we && (rgn == MT_SEG) && (ofs == OFS_DATA);
   assign wr_segen   = we && (rgn == MT_SEG) && (ofs == OFS_STAT);
   assign wr_ovf_clr = we && (rgn == MT_KBD) && (ofs == OFS_STAT);
   // The FIFO ignores a pop while empty, so the request can be raised unconditionally.
   assign kbd_pop    = re && (rgn == MT_KBD) && (ofs == OFS_DATA);

   kbd_fifo #(
      .DEPTH    (KBD_FIFO_DEPTH)
   ) u_kbd_fifo (
      .clock    (clock),
      .rst_n    (rst_n),
      .push     (kbd_valid),
      .din      (kbd_code),
      .pop      (kbd_pop),
      .dout     (kbd_head),
      .empty    (kbd_empty),
      .full     (kbd_full),
      .overflow (kbd_ovf),
      .clr_ovf  (wr_ovf_clr)
   );

   // CPU-writable output registers.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         led      <= '0;
         seg_data <= '0;
         seg_en   <= '0;
      end else begin
         if (wr_led)   led      <= wdata[15:0];
         if (wr_seg)   seg_data <= wdata;
         if (wr_segen) seg_en   <= wdata[7:0];
      end
   end

   // Read request register; the popped head is latched here because the FIFO moves on at the same edge.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sel_rgn <= MT_NONE;
         sel_ofs <= '0;
         kbd_q   <= '0;
      end else if (re) begin
         sel_rgn <= rgn;
         sel_ofs <= ofs;
         if (kbd_pop) kbd_q <= kbd_empty ? 8'h00 : kbd_head;
      end
   end

`ifdef MMIO_TIMER_EN
   localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

   logic          wr_timer;
   logic [PW-1:0] presc;

   assign wr_timer  = we && (rgn == MT_TIMER) && (ofs == OFS_DATA);
   assign unused_ok = ^{addr[19:4], kbd_full};

   // Millisecond timer; a CPU write restarts the prescaler and overrides a coincident tick.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         presc  <= '0;
         ms_cnt <= '0;
      end else if (wr_timer) begin
         presc  <= '0;
         ms_cnt <= wdata;
      end else if (presc == PW'(TIMER_DIV - 1)) begin
         presc  <= '0;
         ms_cnt <= ms_cnt + 32'd1;
      end else begin
         presc  <= presc + PW'(1);
      end
   end
`else
   assign ms_cnt    = '0;
   assign unused_ok = ^{addr[19:4], kbd_full, TIMER_DIV[0]};
`endif

   // Read-data mux keyed by the registered request; DATA/VGA pass through whatever the slave returns.
   always_comb begin
      rdata = '0;
      case (sel_rgn)
         MT_DATA: rdata = dmem_rdata;
         MT_VGA:  rdata = vga_rdata;
         MT_KBD: begin
            if (sel_ofs == OFS_DATA)      rdata = {24'h0, kbd_q};
            else if (sel_ofs == OFS_STAT) rdata = {30'h0, kbd_ovf, ~kbd_empty};
         end
         MT_LED:   if (sel_ofs == OFS_DATA) rdata = {16'h0, led};
         MT_SW:    if (sel_ofs == OFS_DATA) rdata = {16'h0, sw};
         MT_SEG: begin
            if (sel_ofs == OFS_DATA)      rdata = seg_data;
            else if (sel_ofs == OFS_STAT) rdata = {24'h0, seg_en};
         end
         MT_TIMER: if (sel_ofs == OFS_DATA) rdata = ms_cnt;
         default:  rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Purpose: self-checking bench for mmio_ctrl against a queue-based reference model.
// Latency: checks sample 1 ns after the rising edge that completes each access.
// Backpressure: n/a; timer expectations follow MMIO_TIMER_EN as built.
module tb_mmio_ctrl;

   localparam int DEPTH = 8;
   localparam int TDIV  = 4;

   localparam logic [31:0] A_DATA   = 32'h0010_0010;
   localparam logic [31:0] A_KBD    = 32'h0030_0000;
   localparam logic [31:0] A_KBDST  = 32'h0030_0004;
   localparam logic [31:0] A_LED    = 32'h0040_0000;
   localparam logic [31:0] A_SW     = 32'h0050_0000;
   localparam logic [31:0] A_SEG    = 32'h0060_0000;
   localparam logic [31:0] A_SEGEN  = 32'h0060_0004;
   localparam logic [31:0] A_TMR    = 32'h0070_0000;
   localparam logic [31:0] A_NONE   = 32'h0080_0000;

   logic        clock = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [2:0]  mem_type;
   logic [31:0] dmem_rdata = '0;
   logic [31:0] vga_rdata = '0;
   logic [31:0] rdata;
   logic [15:0] sw = '0;
   logic [15:0] led;
   logic [7:0]  seg_en;
   logic [31:0] seg_data;
   logic        kbd_valid = 1'b0;
   logic [7:0]  kbd_code = '0;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [15:0] m_led;
   logic [31:0] m_seg;
   logic [7:0]  m_segen;
   logic [7:0]  q[$];
   logic        m_ovf;
   logic [31:0] m_tbase;
   int          m_tcyc;
   logic [11:0] m_selr;
   logic [3:0]  m_selo;
   logic [7:0]  m_kcap;

   always #5 clock = ~clock;

   mmio_ctrl #(
      .KBD_FIFO_DEPTH (DEPTH),
      .TIMER_DIV      (TDIV)
   ) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .addr       (addr),
      .wdata      (wdata),
      .we         (we),
      .re         (re),
      .mem_type   (mem_type),
      .dmem_rdata (dmem_rdata),
      .vga_rdata  (vga_rdata),
      .rdata      (rdata),
      .sw         (sw),
      .led        (led),
      .seg_en     (seg_en),
      .seg_data   (seg_data),
      .kbd_valid  (kbd_valid),
      .kbd_code   (kbd_code)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Millisecond count implied by the last write and the edges seen since.
   function automatic logic [31:0] m_timer();
`ifdef MMIO_TIMER_EN
      return m_tbase + 32'(m_tcyc / TDIV);
`else
      return 32'h0;
`endif
   endfunction

   function automatic logic [31:0] exp_rdata();
      logic [31:0] r;
      r = '0;
      case (m_selr)
         12'h001: r = dmem_rdata;
         12'h002: r = vga_rdata;
         12'h003: begin
            if (m_selo == 4'h0)      r = {24'h0, m_kcap};
            else if (m_selo == 4'h4) r = {30'h0, m_ovf, (q.size() != 0)};
         end
         12'h004: if (m_selo == 4'h0) r = {16'h0, m_led};
         12'h005: if (m_selo == 4'h0) r = {16'h0, sw};
         12'h006: begin
            if (m_selo == 4'h0)      r = m_seg;
            else if (m_selo == 4'h4) r = {24'h0, m_segen};
         end
         12'h007: if (m_selo == 4'h0) r = m_timer();
         default: r = '0;
      endcase
      return r;
   endfunction

   // Apply the current inputs to the model, then let the DUT take the same edge.
   task automatic step();
      logic [11:0] r;
      logic [3:0]  o;
      bit          full_pre;
      bit          pop_ok;
      r = addr[31:20];
      o = addr[3:0];
      full_pre = (q.size() == DEPTH);
      pop_ok   = re && (r == 12'h003) && (o == 4'h0) && (q.size() != 0);
      if (re) begin
         m_selr = r;
         m_selo = o;
         if (r == 12'h003 && o == 4'h0) m_kcap = pop_ok ? q[0] : 8'h00;
      end
      if (pop_ok) void'(q.pop_front());
      if (we && r == 12'h003 && o == 4'h4) m_ovf = 1'b0;
      if (kbd_valid) begin
         if (!full_pre || pop_ok) q.push_back(kbd_code);
         else m_ovf = 1'b1;
      end
      if (we && r == 12'h004 && o == 4'h0) m_led   = wdata[15:0];
      if (we && r == 12'h006 && o == 4'h0) m_seg   = wdata;
      if (we && r == 12'h006 && o == 4'h4) m_segen = wdata[7:0];
      if (we && r == 12'h007 && o == 4'h0) begin
         m_tbase = wdata;
         m_tcyc  = 0;
      end else begin
         m_tcyc++;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1; re = 1'b0;
      step();
      we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input string tag);
      addr = a; re = 1'b1; we = 1'b0;
      step();
      re = 1'b0;
      check(tag, rdata, exp_rdata());
   endtask

   task automatic push(input logic [7:0] c);
      kbd_valid = 1'b1; kbd_code = c;
      step();
      kbd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic apply_reset();
      we = 1'b0; re = 1'b0; kbd_valid = 1'b0;
      rst_n = 1'b0;
      m_led = '0; m_seg = '0; m_segen = '0; q.delete(); m_ovf = 1'b0;
      m_tbase = '0; m_tcyc = 0; m_selr = '0; m_selo = '0; m_kcap = '0;
      #2;
      check("rst_led", {16'h0, led}, 32'h0);
      check("rst_seg_en", {24'h0, seg_en}, 32'h0);
      check("rst_seg_data", seg_data, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      @(posedge clock);
      @(posedge clock);
      #1;
      rst_n = 1'b1;
   endtask

   logic [7:0] codes [9];

   initial begin
      codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h21; codes[3] = 8'h23; codes[4] = 8'h24;
      codes[5] = 8'h2B; codes[6] = 8'h34; codes[7] = 8'h33; codes[8] = 8'h43;
      #1;
      apply_reset();

      // Reset in the middle of activity
      wr(A_LED, 32'h0000_00A5);
      check("led_a5", {16'h0, led}, 32'h0000_00A5);
      push(8'h11);
      push(8'h22);
      rd(A_KBDST, "kbd_stat_2");
      check("kbd_stat_2_const", rdata, 32'h1);
      addr = A_KBD; re = 1'b1;
      apply_reset();
      rd(A_KBDST, "kbd_stat_after_rst");
      check("kbd_stat_after_rst_const", rdata, 32'h0);

      // Switches and LEDs
      sw = 16'h1234;
      rd(A_SW, "sw_read");
      check("sw_read_const", rdata, 32'h0000_1234);
      wr(A_LED, 32'hFFFF_BEEF);
      check("led_beef", {16'h0, led}, 32'h0000_BEEF);
      rd(A_LED, "led_read");

      // 7-segment registers
      wr(A_SEG, 32'h8765_4321);
      wr(A_SEGEN, 32'hFFFF_FF3C);
      check("seg_data", seg_data, 32'h8765_4321);
      check("seg_en", {24'h0, seg_en}, 32'h0000_003C);
      rd(A_SEG, "seg_read");
      rd(A_SEGEN, "segen_read");

      // FIFO fill past capacity, drain in order, then underflow
      for (int i = 0; i < 9; i++) push(codes[i]);
      rd(A_KBDST, "kbd_ovf_stat");
      check("kbd_ovf_stat_const", rdata, 32'h3);
      for (int i = 0; i < 8; i++) begin
         rd(A_KBD, "kbd_pop");
         check("kbd_pop_order", rdata, {24'h0, codes[i]});
      end
      rd(A_KBD, "kbd_pop_empty");
      check("kbd_pop_empty_const", rdata, 32'h0);
      wr(A_KBDST, 32'h0);
      rd(A_KBDST, "kbd_ovf_clr");
      check("kbd_ovf_clr_const", rdata, 32'h0);

      // Simultaneous push and pop with one entry queued
      push(8'h1C);
      addr = A_KBD; re = 1'b1; kbd_valid = 1'b1; kbd_code = 8'h23;
      step();
      re = 1'b0; kbd_valid = 1'b0;
      check("kbd_pushpop_rd", rdata, 32'h0000_001C);
      rd(A_KBDST, "kbd_pushpop_cnt");
      check("kbd_pushpop_cnt_const", rdata, 32'h1);
      rd(A_KBD, "kbd_pushpop_next");
      check("kbd_pushpop_next_const", rdata, 32'h0000_0023);

      // Timer wrap and write-over-tick
      wr(A_TMR, 32'hFFFF_FFFF);
      idle(3);
      rd(A_TMR, "tmr_wrap");
      check("tmr_wrap_const", rdata, 32'h0);
      idle(3);
      wr(A_TMR, 32'h1234_5678);
      rd(A_TMR, "tmr_tick_write");
`ifdef MMIO_TIMER_EN
      check("tmr_tick_write_const", rdata, 32'h1234_5678);
`else
      check("tmr_tick_write_const", rdata, 32'h0);
`endif

      // Decode
      addr = A_DATA; #1;
      check("mt_data", {29'h0, mem_type}, 32'h1);
      dmem_rdata = 32'hCAFE_F00D;
      rd(A_DATA, "data_read");
      check("data_read_const", rdata, 32'hCAFE_F00D);
      vga_rdata = 32'h0BAD_C0DE;
      rd(32'h0020_0008, "vga_read");
      addr = A_NONE; #1;
      check("mt_none", {29'h0, mem_type}, 32'h0);
      rd(A_NONE, "none_read");
      check("none_read_const", rdata, 32'h0);
      wr(A_NONE, 32'h0000_5555);
      check("none_wr_led", {16'h0, led}, 32'h0000_BEEF);
      check("none_wr_seg", seg_data, 32'h8765_4321);

      // Randomised traffic against the model
      for (int i = 0; i < 600; i++) begin
         int          rg;
         logic [3:0]  o;
         logic        rd_now;
         rg = $urandom_range(0, 8);
         o  = ((rg == 3 || rg == 6) && $urandom_range(0, 1) == 1) ? 4'h4 : 4'h0;
         addr       = {12'(rg), 16'($urandom), o};
         wdata      = $urandom;
         we         = ($urandom_range(0, 3) == 0);
         rd_now     = ($urandom_range(0, 1) == 1);
         re         = rd_now;
         kbd_valid  = ($urandom_range(0, 2) == 0) && !(we && rg == 3 && o == 4'h4);
         kbd_code   = 8'($urandom);
         sw         = 16'($urandom);
         dmem_rdata = $urandom;
         vga_rdata  = $urandom;
         step();
         if (rd_now) check("rand_rdata", rdata, exp_rdata());
         if (i % 16 == 0) begin
            check("rand_led", {16'h0, led}, {16'h0, m_led});
            check("rand_seg", seg_data, m_seg);
            check("rand_segen", {24'h0, seg_en}, {24'h0, m_segen});
         end
      end
      we = 1'b0; re = 1'b0; kbd_valid = 1'b0;
      rd(A_KBDST, "final_kbd_stat");
      rd(A_TMR, "final_timer");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
